// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 datapath: ALU operation codes.
package cpu6502_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [OP_W-1:0] ALU_SBC   = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [OP_W-1:0] ALU_EOR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_SR    = 4'd5;
  localparam logic [OP_W-1:0] ALU_PASSA = 4'd6;

endpackage

// File: rtl/decadj_adder.sv
// Per-nibble BCD post-correction of the SB bus value; nibbles wrap independently.
module decadj_adder
  import cpu6502_pkg::*;
(
  input  logic [DATA_W-1:0] adj_in,
  input  logic              carry,
  input  logic              half_carry,
  input  logic              dec_add,
  input  logic              dec_sub,
  output logic [DATA_W-1:0] adj_out
);

  logic [3:0] lo_nib;
  logic [3:0] hi_nib;

  // Add 6 after a decimal carry, subtract 6 after a decimal borrow; add mode has priority
  always_comb begin
    lo_nib = adj_in[3:0];
    hi_nib = adj_in[7:4];
    if (dec_add) begin
      if (half_carry) lo_nib = adj_in[3:0] + 4'd6;
      if (carry)      hi_nib = adj_in[7:4] + 4'd6;
    end else if (dec_sub) begin
      if (!half_carry) lo_nib = adj_in[3:0] - 4'd6;
      if (!carry)      hi_nib = adj_in[7:4] - 4'd6;
    end
    adj_out = {hi_nib, lo_nib};
  end

endmodule

// File: rtl/cpu6502_alu_stage.sv
// 6502 ALU stage: latched A/B operands, binary/NMOS-decimal arithmetic,
// logic ops, shift right, and the decimal-adjust adder on the SB path.
module cpu6502_alu_stage
  import cpu6502_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_load,
  input  logic [OP_W-1:0]   op,
  input  logic              c_in,
  input  logic              dec_add,
  input  logic              dec_sub,
  input  logic [DATA_W-1:0] adj_in,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out,
  output logic              half_carry_out,
  output logic              overflow_out,
  output logic              carry_last,
  output logic              a_reg_msb,
  output logic [DATA_W-1:0] adj_out
);

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [4:0]        lo_sum;
  logic [4:0]        hi_sum;
  logic              lo_carry;
  logic              hi_carry;
  logic [DATA_W-1:0] sum;

  // Operand latches and the one-cycle-delayed carry used for address high bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_last <= 1'b0;
    end else begin
      a_reg      <= a_in;
      if (b_load) b_reg <= b_in;
      carry_last <= carry_out;
    end
  end

  // Nibble adder; decimal mode only changes carry detection, not the sum bits
  always_comb begin
    lo_sum   = 5'({1'b0, a_reg[3:0]}) + 5'({1'b0, b_reg[3:0]}) + 5'(c_in);
    lo_carry = dec_add ? (lo_sum > 5'd9) : lo_sum[4];
    hi_sum   = 5'({1'b0, a_reg[7:4]}) + 5'({1'b0, b_reg[7:4]}) + 5'(lo_carry);
    hi_carry = dec_add ? (hi_sum > 5'd9) : hi_sum[4];
    sum      = {hi_sum[3:0], lo_sum[3:0]};
  end

  // Result and flag select; codes above PASSA fall through to PASSA
  always_comb begin
    alu_out        = a_reg;
    carry_out      = 1'b0;
    half_carry_out = 1'b0;
    overflow_out   = 1'b0;
    case (op)
      ALU_ADD, ALU_SBC: begin
        alu_out        = sum;
        carry_out      = hi_carry;
        half_carry_out = lo_carry;
        overflow_out   = (a_reg[7] ^ sum[7]) & (b_reg[7] ^ sum[7]);
      end
      ALU_AND: alu_out = a_reg & b_reg;
      ALU_OR:  alu_out = a_reg | b_reg;
      ALU_EOR: alu_out = a_reg ^ b_reg;
      ALU_SR: begin
        alu_out   = {c_in, a_reg[7:1]};
        carry_out = a_reg[0];
      end
      default: alu_out = a_reg;
    endcase
  end

  assign a_reg_msb = a_reg[7];

  decadj_adder u_decadj (
    .adj_in     (adj_in),
    .carry      (carry_out),
    .half_carry (half_carry_out),
    .dec_add    (dec_add),
    .dec_sub    (dec_sub),
    .adj_out    (adj_out)
  );

endmodule

// File: tb/tb_cpu6502_alu_stage.sv
// Scoreboard bench for cpu6502_alu_stage: directed vectors push expectations,
// a negedge monitor pops and compares while chk_valid is high.
module tb_cpu6502_alu_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in, b_in, adj_in;
  logic       b_load;
  logic [3:0] op;
  logic       c_in, dec_add, dec_sub;
  logic [7:0] alu_out, adj_out;
  logic       carry_out, half_carry_out, overflow_out, carry_last, a_reg_msb;

  typedef struct {
    string      name;
    logic [7:0] alu;
    logic       c;
    logic       h;
    logic       v;
    logic       msb;
    logic [7:0] adj;
    logic       cl_chk;
    logic       cl;
  } exp_t;

  exp_t sb[$];
  logic chk_valid = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu6502_alu_stage dut (
    .clk            (clk),
    .reset          (reset),
    .a_in           (a_in),
    .b_in           (b_in),
    .b_load         (b_load),
    .op             (op),
    .c_in           (c_in),
    .dec_add        (dec_add),
    .dec_sub        (dec_sub),
    .adj_in         (adj_in),
    .alu_out        (alu_out),
    .carry_out      (carry_out),
    .half_carry_out (half_carry_out),
    .overflow_out   (overflow_out),
    .carry_last     (carry_last),
    .a_reg_msb      (a_reg_msb),
    .adj_out        (adj_out)
  );

  task automatic cmp(input string n, input string f, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%02h want=%02h", n, f, act, req);
    end
  endtask

  // Monitor: one expectation consumed per sampled negedge
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard empty at check time");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "alu", alu_out, e.alu);
        cmp(e.name, "c", 8'(carry_out), 8'(e.c));
        cmp(e.name, "h", 8'(half_carry_out), 8'(e.h));
        cmp(e.name, "v", 8'(overflow_out), 8'(e.v));
        cmp(e.name, "msb", 8'(a_reg_msb), 8'(e.msb));
        cmp(e.name, "adj", adj_out, e.adj);
        if (e.cl_chk) cmp(e.name, "carry_last", 8'(carry_last), 8'(e.cl));
      end
    end
  end

  task automatic push(input string n, input logic [7:0] ea, input logic ec, eh, ev, em,
                      input logic [7:0] eadj, input logic clc, input logic cl);
    exp_t e;
    e.name = n; e.alu = ea; e.c = ec; e.h = eh; e.v = ev; e.msb = em;
    e.adj = eadj; e.cl_chk = clc; e.cl = cl;
    sb.push_back(e);
  endtask

  // Drive one vector: operands latch at the first edge, checked after the second
  task automatic apply(input string n, input logic [7:0] a, b, input logic bl,
                       input logic [3:0] o, input logic ci, da, ds, input logic [7:0] adj,
                       input logic [7:0] ea, input logic ec, eh, ev, input logic [7:0] eadj);
    @(posedge clk); #1;
    chk_valid = 1'b0;
    a_in = a; b_in = b; b_load = bl; op = o; c_in = ci;
    dec_add = da; dec_sub = ds; adj_in = adj;
    @(posedge clk); #1;
    push(n, ea, ec, eh, ev, a[7], eadj, 1'b0, 1'b0);
    chk_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; a_in = 8'h00; b_in = 8'h00; b_load = 1'b0; op = 4'd0;
    c_in = 1'b0; dec_add = 1'b0; dec_sub = 1'b0; adj_in = 8'h3C;

    // Reset state: zero operands, ADD c=0
    @(posedge clk); @(posedge clk); #1;
    push("reset0", 8'h00, 0, 0, 0, 0, 8'h3C, 1'b1, 1'b0);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
    reset = 1'b0;

    //     name        a      b      bl o  ci da ds adj    alu    c  h  v  adj
    apply("add_v",   8'h50, 8'h50, 1, 0, 0, 0, 0, 8'h12, 8'hA0, 0, 0, 1, 8'h12);
    apply("add_7f",  8'h7F, 8'h01, 1, 0, 0, 0, 0, 8'h80, 8'h80, 0, 1, 1, 8'h80);
    apply("dadd",    8'h19, 8'h28, 1, 0, 0, 1, 0, 8'h41, 8'h41, 0, 1, 0, 8'h47);
    apply("dadd_wr", 8'h99, 8'h01, 1, 0, 0, 1, 0, 8'hAA, 8'hAA, 1, 1, 0, 8'h00);
    apply("dsub",    8'h10, 8'hFE, 1, 1, 1, 0, 1, 8'h0F, 8'h0F, 1, 0, 0, 8'h09);
    apply("dboth",   8'h08, 8'h08, 1, 0, 0, 1, 1, 8'h10, 8'h10, 0, 1, 0, 8'h16);
    apply("sr",      8'h81, 8'h00, 1, 5, 1, 0, 0, 8'h55, 8'hC0, 1, 0, 0, 8'h55);
    apply("eor",     8'hF0, 8'hFF, 1, 4, 0, 0, 0, 8'h01, 8'h0F, 0, 0, 0, 8'h01);
    apply("and",     8'hCA, 8'h0F, 1, 2, 1, 0, 0, 8'h02, 8'h0A, 0, 0, 0, 8'h02);
    apply("or",      8'hCA, 8'h05, 1, 3, 0, 0, 0, 8'h03, 8'hCF, 0, 0, 0, 8'h03);
    apply("rsvd9",   8'h5A, 8'hFF, 1, 9, 1, 0, 0, 8'h04, 8'h5A, 0, 0, 0, 8'h04);
    apply("hold_ld", 8'h01, 8'h02, 1, 0, 0, 0, 0, 8'h05, 8'h03, 0, 0, 0, 8'h05);
    apply("hold_b",  8'h03, 8'h10, 0, 0, 0, 0, 0, 8'h06, 8'h05, 0, 0, 0, 8'h06);
    apply("add_c",   8'h80, 8'h80, 1, 0, 0, 0, 0, 8'h07, 8'h00, 1, 0, 1, 8'h07);

    // Same inputs one more cycle: carry_last now holds the ADD carry
    @(posedge clk); #1;
    push("carry_last", 8'h00, 1, 0, 1, 1, 8'h07, 1'b1, 1'b1);

    // Reset with b_load asserted: registers and carry_last clear
    @(posedge clk); #1;
    chk_valid = 1'b0;
    reset = 1'b1; a_in = 8'h55; b_in = 8'h66; b_load = 1'b1;
    op = 4'd0; c_in = 1'b0; dec_add = 1'b0; dec_sub = 1'b0; adj_in = 8'h3C;
    @(posedge clk); #1;
    push("reset1", 8'h00, 0, 0, 0, 0, 8'h3C, 1'b1, 1'b0);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
